// File: rtl/tiny_fir_pkg.sv
// Shared types for the FIR tap loader.
// State encoding and skid buffer depth.
package tiny_fir_pkg;

  typedef enum logic [1:0] {
    SM_IDLE      = 2'd0,
    SM_STREAM    = 2'd1,
    SM_WAIT_DONE = 2'd2,
    SM_DONE      = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/tiny_fir_tap_loader_if.sv
// Config-write and tap-stream bundle.
// master = loader side, slave = host/FIR side.
interface tiny_fir_tap_loader_if #(
  parameter int G_NUM_TAPS  = 16,
  parameter int G_TAP_WIDTH = 16
);
  localparam int AW = $clog2(G_NUM_TAPS);

  logic [AW-1:0]          cfg_wr_addr;
  logic [G_TAP_WIDTH-1:0] cfg_wr_data;
  logic                   cfg_wr_valid;
  logic                   cfg_wr_ready;
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;
  logic                   tap_dout_last;
  logic                   tap_dout_done;

  modport master (
    input  cfg_wr_addr, cfg_wr_data, cfg_wr_valid,
    input  tap_dout_ready, tap_dout_done,
    output cfg_wr_ready, tap_dout, tap_dout_valid,
    output tap_dout_last
  );

  modport slave (
    output cfg_wr_addr, cfg_wr_data, cfg_wr_valid,
    output tap_dout_ready, tap_dout_done,
    input  cfg_wr_ready, tap_dout, tap_dout_valid,
    input  tap_dout_last
  );
endinterface

// File: rtl/tiny_fir_bram.sv
// Simple dual-port coefficient RAM.
// Registered read (1-cycle latency), contents never reset.
module tiny_fir_bram #(
  parameter int G_ADDR_WIDTH = 4,
  parameter int G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [G_ADDR_WIDTH-1:0] waddr,
  input  logic [G_DATA_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [G_ADDR_WIDTH-1:0] raddr,
  output logic [G_DATA_WIDTH-1:0] rdata
);

  logic [G_DATA_WIDTH-1:0] mem_q [2**G_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/tiny_fir_tap_loader.sv
// Streams stored FIR coefficients in index order.
// Read-ahead into a 2-entry skid buffer for full rate.
module tiny_fir_tap_loader
  import tiny_fir_pkg::*;
#(
  parameter int G_NUM_TAPS  = 16,
  parameter int G_TAP_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic start,
  output logic busy,
  output logic done,
  tiny_fir_tap_loader_if.master bus
);

  localparam int AW = $clog2(G_NUM_TAPS);
  localparam logic [AW-1:0] LAST = AW'(G_NUM_TAPS - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  state_t state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_fin_q, rd_fin_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [G_TAP_WIDTH-1:0] head_q, head_d;
  logic [G_TAP_WIDTH-1:0] tail_q, tail_d;

  logic [G_TAP_WIDTH-1:0] rdata;
  logic       in_stream, pop, push, rd_en, wr_en;
  logic [2:0] occ;

  // Async assert, synchronous release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  tiny_fir_bram #(
    .G_ADDR_WIDTH(AW),
    .G_DATA_WIDTH(G_TAP_WIDTH)
  ) u_bram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(bus.cfg_wr_addr),
    .wdata(bus.cfg_wr_data),
    .re   (rd_en),
    .raddr(rd_addr_q),
    .rdata(rdata)
  );

  assign bus.cfg_wr_ready   = (state_q == SM_IDLE);
  assign bus.tap_dout_valid = (cnt_q != 2'd0);
  assign bus.tap_dout       = head_q;
  assign bus.tap_dout_last  = bus.tap_dout_valid
                            && (beat_q == LAST);
  assign busy  = (state_q != SM_IDLE);
  assign done  = (state_q == SM_DONE);
  assign wr_en = bus.cfg_wr_valid && bus.cfg_wr_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SM_IDLE:      if (start) state_d = SM_STREAM;
      SM_STREAM:    if (pop && beat_q == LAST)
                      state_d = SM_WAIT_DONE;
      SM_WAIT_DONE: if (bus.tap_dout_done)
                      state_d = SM_DONE;
      SM_DONE:      state_d = SM_IDLE;
      default:      state_d = SM_IDLE;
    endcase
    if (!enable) state_d = SM_IDLE;
  end

  // Issue a read only if the skid buffer can absorb it.
  always_comb begin
    in_stream = (state_q == SM_STREAM) && enable;
    pop  = bus.tap_dout_valid && bus.tap_dout_ready;
    push = rd_pend_q;
    occ  = {1'b0, cnt_q} + {2'b0, rd_pend_q}
         - {2'b0, pop};
    rd_en = in_stream && !rd_fin_q
          && (occ < 3'(SKID_DEPTH));

    rd_addr_d = rd_addr_q;
    rd_fin_d  = rd_fin_q;
    rd_pend_d = rd_en;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (rd_en) begin
      if (rd_addr_q == LAST) rd_fin_d = 1'b1;
      else rd_addr_d = rd_addr_q + AW'(1);
    end
    if (pop) beat_d = beat_q + AW'(1);

    unique case (cnt_q)
      2'd0: if (push) begin
        head_d = rdata;
        cnt_d  = 2'd1;
      end
      2'd1: begin
        if (pop && push) head_d = rdata;
        else if (pop) cnt_d = 2'd0;
        else if (push) begin
          tail_d = rdata;
          cnt_d  = 2'd2;
        end
      end
      2'd2: if (pop) begin
        head_d = tail_q;
        if (push) tail_d = rdata;
        else cnt_d = 2'd1;
      end
      default: cnt_d = 2'd0;
    endcase

    if (!in_stream) begin
      rd_addr_d = '0;
      rd_fin_d  = 1'b0;
      rd_pend_d = 1'b0;
      beat_d    = '0;
      cnt_d     = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SM_IDLE;
      rd_addr_q <= '0;
      rd_fin_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      beat_q    <= '0;
      cnt_q     <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_fin_q  <= rd_fin_d;
      rd_pend_q <= rd_pend_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule

// File: tb/tb_tiny_fir_tap_loader.sv
// Directed bench for tiny_fir_tap_loader.
// Four 16-bit taps, hand-computed expectations.
module tb_tiny_fir_tap_loader;

  localparam int NT = 4;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_v [NT];

  tiny_fir_tap_loader_if #(
    .G_NUM_TAPS(NT), .G_TAP_WIDTH(TW)
  ) bus ();

  tiny_fir_tap_loader #(
    .G_NUM_TAPS(NT), .G_TAP_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start(start), .busy(busy), .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [15:0] d);
    bus.cfg_wr_addr  = a;
    bus.cfg_wr_data  = d;
    bus.cfg_wr_valid = 1'b1;
    step();
    bus.cfg_wr_valid = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic collect(input logic [3:0] rpat);
    int idx;
    bit stalled;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx == NT) break;
      bus.tap_dout_ready = rpat[c % 4];
      stalled = 1'b0;
      if (bus.tap_dout_valid) begin
        chk("beat_data", 32'(bus.tap_dout),
            32'(exp_v[idx]));
        chk("beat_last", 32'(bus.tap_dout_last),
            32'(idx == NT - 1));
        if (bus.tap_dout_ready) idx++;
        else stalled = 1'b1;
      end
      step();
      if (stalled)
        chk("stall_valid",
            32'(bus.tap_dout_valid), 32'd1);
    end
    chk("beat_count", 32'(idx), 32'(NT));
    bus.tap_dout_ready = 1'b1;
  endtask

  task automatic finish_seq();
    bus.tap_dout_done = 1'b1;
    step();
    chk("done_pulse", 32'(done), 32'd1);
    bus.tap_dout_done = 1'b0;
    step();
    chk("done_clear", 32'(done), 32'd0);
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    bus.cfg_wr_addr    = '0;
    bus.cfg_wr_data    = '0;
    bus.cfg_wr_valid   = 1'b0;
    bus.tap_dout_ready = 1'b0;
    bus.tap_dout_done  = 1'b0;
    exp_v = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

    // reset values
    #2 reset = 1'b0;
    #10;
    chk("rst_valid", 32'(bus.tap_dout_valid), 32'd0);
    chk("rst_last", 32'(bus.tap_dout_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(bus.tap_dout), 32'd0);
    step();
    reset = 1'b1;
    step(); step(); step();
    chk("rst_cfg_ready", 32'(bus.cfg_wr_ready), 32'd1);

    for (int i = 0; i < NT; i++)
      wr(2'(i), exp_v[i]);

    // latency and full-rate stream
    bus.tap_dout_ready = 1'b1;
    kick();
    chk("k0_valid", 32'(bus.tap_dout_valid), 32'd0);
    chk("k0_busy", 32'(busy), 32'd1);
    chk("k0_cfg_ready", 32'(bus.cfg_wr_ready), 32'd0);
    step();
    chk("k1_valid", 32'(bus.tap_dout_valid), 32'd0);
    for (int i = 0; i < NT; i++) begin
      step();
      chk("fr_valid", 32'(bus.tap_dout_valid), 32'd1);
      chk("fr_data", 32'(bus.tap_dout), 32'(exp_v[i]));
      chk("fr_last", 32'(bus.tap_dout_last),
          32'(i == NT - 1));
    end
    step();
    chk("fr_end_valid", 32'(bus.tap_dout_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    step(); step();
    chk("wait_no_done", 32'(done), 32'd0);
    finish_seq();

    // ready toggling 1,0,1,0
    kick();
    collect(4'b0101);
    chk("tog_no_dup", 32'(bus.tap_dout_valid), 32'd0);
    finish_seq();

    // long stall, tap_dout_done ignored in stream
    kick();
    bus.tap_dout_ready = 1'b0;
    bus.tap_dout_done  = 1'b1;
    step(); step();
    for (int j = 0; j < 5; j++) begin
      chk("hold_valid", 32'(bus.tap_dout_valid), 32'd1);
      chk("hold_data", 32'(bus.tap_dout), 32'h0001);
      step();
    end
    chk("hold_busy", 32'(busy), 32'd1);
    bus.tap_dout_done = 1'b0;
    collect(4'b1111);
    finish_seq();

    // reset after the second beat
    kick();
    step(); step(); step(); step();
    chk("pre_rst_data", 32'(bus.tap_dout), 32'h0003);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.tap_dout_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    step(); step();
    chk("arst_hold", 32'(bus.tap_dout_valid), 32'd0);
    reset = 1'b1;
    step(); step(); step();
    chk("rel_cfg_ready", 32'(bus.cfg_wr_ready), 32'd1);
    kick();
    collect(4'b1111);
    finish_seq();

    // write and start while busy are dropped
    kick();
    step();
    bus.cfg_wr_addr  = 2'd2;
    bus.cfg_wr_data  = 16'hBEEF;
    bus.cfg_wr_valid = 1'b1;
    start = 1'b1;
    step();
    bus.cfg_wr_valid = 1'b0;
    start = 1'b0;
    collect(4'b1111);
    finish_seq();
    step();
    chk("no_restart", 32'(busy), 32'd0);
    kick();
    collect(4'b1111);
    finish_seq();

    // write and start in the same idle cycle
    exp_v[0] = 16'h0011;
    bus.cfg_wr_addr  = 2'd0;
    bus.cfg_wr_data  = 16'h0011;
    bus.cfg_wr_valid = 1'b1;
    start = 1'b1;
    step();
    bus.cfg_wr_valid = 1'b0;
    start = 1'b0;
    collect(4'b1111);
    finish_seq();

    // enable drop during WAIT_DONE
    kick();
    collect(4'b1111);
    chk("en_wait_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    step();
    chk("en_idle", 32'(busy), 32'd0);
    chk("en_no_done", 32'(done), 32'd0);
    enable = 1'b1;
    bus.tap_dout_done = 1'b1;
    step();
    chk("late_done_0", 32'(done), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    step();
    chk("late_done_1", 32'(done), 32'd0);
    bus.tap_dout_done = 1'b0;

    // memory retained across enable drop
    kick();
    collect(4'b1111);
    finish_seq();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
